piezo_rx: RTL and testbench

PIEZO_RX -- requirements
Module: piezo_rx

---
 rtl/piezo_rx.sv | 198 +++++++++++++++++++
 tb/tb_piezo_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_rx.sv
// rtl/piezo_rx.sv - piezo tone receiver: classifies edge periods into G6/C7/E7/G7 note events.
// Optional PIEZO_RX_FIFO_EN selects a 4-entry event FIFO instead of a single holding register.
module piezo_rx #(
  parameter int G6_PER  = 31888,
  parameter int C7_PER  = 23889,
  parameter int E7_PER  = 18961,
  parameter int G7_PER  = 15944,
  parameter int TOL     = 512,
  parameter int SIL_LEN = 32767
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        piezo_in,
  input  logic        note_rdy,
  input  logic        ovf_clr,
  output logic        note_vld,
  output logic [1:0]  note_id,
  output logic [26:0] note_dur,
  output logic        tone_on,
  output logic        bad_per,
  output logic        ovf
);

  localparam logic [14:0] SIL     = 15'(SIL_LEN);
  localparam logic [26:0] DUR_MAX = '1;

  typedef enum logic [1:0] {IDLE, FIRST, TONE} state_t;

  logic        sync1, sync2, sync3, edge_q;
  logic [14:0] per_cnt;
  logic        cls_ok;
  logic [1:0]  cls_id;
  logic [27:0] dur_sum;
  logic [26:0] dur_add;
  logic        timeout;
  state_t      state, state_nxt;
  logic [1:0]  cur_id, id_nxt;
  logic [26:0] dur, dur_nxt;
  logic        emit, bad_nxt, pop, drop;

  // Two synchroniser flops, then a history flop; the rising-edge flag is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync1  <= piezo_in;
      sync2  <= sync1;
      sync3  <= sync2;
      edge_q <= sync2 & ~sync3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              per_cnt <= '0;
    else if (edge_q)         per_cnt <= 15'd1;
    else if (per_cnt < SIL)  per_cnt <= per_cnt + 15'd1;
  end

  function automatic logic in_win(input logic [14:0] p, input int per);
    int d;
    d = int'(p) - per;
    return (d >= -TOL) && (d <= TOL);
  endfunction

  always_comb begin
    cls_ok = 1'b1;
    cls_id = 2'd0;
    if (in_win(per_cnt, G6_PER))      cls_id = 2'd0;
    else if (in_win(per_cnt, C7_PER)) cls_id = 2'd1;
    else if (in_win(per_cnt, E7_PER)) cls_id = 2'd2;
    else if (in_win(per_cnt, G7_PER)) cls_id = 2'd3;
    else                              cls_ok = 1'b0;
  end

  assign dur_sum = {1'b0, dur} + {13'b0, per_cnt};
  assign dur_add = dur_sum[27] ? DUR_MAX : dur_sum[26:0];
  assign timeout = (per_cnt == SIL);

  // Emitted events always carry the note held before this cycle's decision.
  always_comb begin
    state_nxt = state;
    id_nxt    = cur_id;
    dur_nxt   = dur;
    emit      = 1'b0;
    bad_nxt   = 1'b0;
    case (state)
      IDLE: if (edge_q) state_nxt = FIRST;
      FIRST: begin
        if (edge_q) begin
          if (cls_ok) begin
            state_nxt = TONE;
            id_nxt    = cls_id;
            dur_nxt   = 27'(per_cnt);
          end else begin
            bad_nxt = 1'b1;
          end
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      TONE: begin
        if (edge_q) begin
          if (!cls_ok) begin
            bad_nxt   = 1'b1;
            emit      = 1'b1;
            state_nxt = FIRST;
          end else if (cls_id == cur_id) begin
            dur_nxt = dur_add;
          end else begin
            emit    = 1'b1;
            id_nxt  = cls_id;
            dur_nxt = 27'(per_cnt);
          end
        end else if (timeout) begin
          emit      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_id  <= 2'd0;
      dur     <= '0;
      bad_per <= 1'b0;
    end else begin
      state   <= state_nxt;
      cur_id  <= id_nxt;
      dur     <= dur_nxt;
      bad_per <= bad_nxt;
    end
  end

  assign tone_on = (state == TONE);
  assign pop     = note_vld && note_rdy;

`ifdef PIEZO_RX_FIFO_EN
  logic [28:0] mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        push_ok;

  assign push_ok = emit && ((count != 3'd4) || pop);
  assign drop    = emit && !push_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {cur_id, dur};
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push_ok} - {2'b0, pop};
    end
  end

  assign note_vld            = (count != 3'd0);
  assign {note_id, note_dur} = mem[rd_ptr];
`else
  logic accept;

  // A pop in the same cycle frees the register for the arriving event.
  assign accept = emit && (!note_vld || note_rdy);
  assign drop   = emit && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_vld <= 1'b0;
      note_id  <= 2'd0;
      note_dur <= '0;
    end else if (accept) begin
      note_vld <= 1'b1;
      note_id  <= cur_id;
      note_dur <= dur;
    end else if (pop) begin
      note_vld <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_piezo_rx.sv
// tb/tb_piezo_rx.sv - self-checking bench for piezo_rx with an interval-level note model.
module tb_piezo_rx;

  localparam int G6 = 320, C7 = 240, E7 = 190, G7 = 160, TOL = 5, SIL = 400;
  localparam int DUR_MAX = (1 << 27) - 1;

  logic        clk, rst_n, piezo_in, note_rdy, ovf_clr;
  logic        note_vld, tone_on, bad_per, ovf;
  logic [1:0]  note_id;
  logic [26:0] note_dur;

  typedef struct {int id; int dur;} ev_t;
  ev_t exp_q[$];
  int  ivs[$];
  int  compared = 0, mismatched = 0, bad_seen = 0, exp_bad = 0;
  bit  rand_rdy = 0, prev_hold = 0;
  int  prev_id = 0, prev_dur = 0;

  piezo_rx #(.G6_PER(G6), .C7_PER(C7), .E7_PER(E7), .G7_PER(G7), .TOL(TOL), .SIL_LEN(SIL)) dut (
    .clk(clk), .rst_n(rst_n), .piezo_in(piezo_in), .note_rdy(note_rdy), .ovf_clr(ovf_clr),
    .note_vld(note_vld), .note_id(note_id), .note_dur(note_dur),
    .tone_on(tone_on), .bad_per(bad_per), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int per_of(input int k);
    case (k)
      0: return G6;
      1: return C7;
      2: return E7;
      default: return G7;
    endcase
  endfunction

  function automatic int classify(input int p);
    for (int k = 0; k < 4; k++)
      if (p >= per_of(k) - TOL && p <= per_of(k) + TOL) return k;
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_ev(input int id, input int dur);
    ev_t e;
    e.id = id;
    e.dur = dur;
    exp_q.push_back(e);
  endtask

  // Walk the intervals following a burst's first edge; the burst always ends in silence.
  task automatic run_model();
    int st = 1;
    int id = 0;
    longint dur = 0;
    int c;
    foreach (ivs[i]) begin
      c = classify(ivs[i]);
      if (st == 1) begin
        if (c >= 0) begin st = 2; id = c; dur = ivs[i]; end
        else exp_bad++;
      end else if (c < 0) begin
        exp_bad++; push_ev(id, int'(dur)); st = 1;
      end else if (c == id) begin
        dur = dur + ivs[i];
        if (dur > DUR_MAX) dur = DUR_MAX;
      end else begin
        push_ev(id, int'(dur)); id = c; dur = ivs[i];
      end
    end
    if (st == 2) push_ev(id, int'(dur));
  endtask

  task automatic monitor();
    ev_t e;
    if (!rst_n) begin
      prev_hold = 0;
      return;
    end
    if (prev_hold) begin
      compared++;
      if (!note_vld || int'(note_id) != prev_id || int'(note_dur) != prev_dur) begin
        mismatched++;
        $display("FAIL hold_stable: vld=%0d id=%0d dur=%0d, required vld=1 id=%0d dur=%0d",
                 note_vld, note_id, note_dur, prev_id, prev_dur);
      end
    end
    if (note_vld && note_rdy) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_event: got id=%0d dur=%0d, required no event", note_id, note_dur);
      end else begin
        e = exp_q.pop_front();
        if (int'(note_id) != e.id || int'(note_dur) != e.dur) begin
          mismatched++;
          $display("FAIL event: got id=%0d dur=%0d, required id=%0d dur=%0d",
                   note_id, note_dur, e.id, e.dur);
        end
      end
    end
    if (bad_per) bad_seen++;
    prev_hold = note_vld && !note_rdy;
    prev_id   = int'(note_id);
    prev_dur  = int'(note_dur);
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rand_rdy) note_rdy = ($urandom_range(0, 9) < 7);
  endtask

  task automatic edge_after(input int p);
    repeat (p - 20) cyc();
    piezo_in = 1'b1;
    repeat (20) cyc();
    piezo_in = 1'b0;
  endtask

  task automatic silence();
    repeat (SIL + 30) cyc();
  endtask

  task automatic drive_ivs();
    edge_after(200);
    foreach (ivs[i]) edge_after(ivs[i]);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      cyc();
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; piezo_in = 1'b0; note_rdy = 1'b0; ovf_clr = 1'b0;
    repeat (3) cyc();
    check("rst_note_vld", int'(note_vld), 0);
    check("rst_note_id", int'(note_id), 0);
    check("rst_note_dur", int'(note_dur), 0);
    check("rst_tone_on", int'(tone_on), 0);
    check("rst_bad_per", int'(bad_per), 0);
    check("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1; note_rdy = 1'b1;
    repeat (5) cyc();

    // Ten C7 edges then silence.
    ivs.delete();
    repeat (9) ivs.push_back(C7);
    run_model();
    check("pin_c7_count", exp_q.size(), 1);
    check("pin_c7_id", exp_q[0].id, 1);
    check("pin_c7_dur", exp_q[0].dur, 2160);
    drive_ivs();
    check("c7_tone_on", int'(tone_on), 1);
    silence();
    check("c7_tone_off", int'(tone_on), 0);
    drain("c7_drain");

    // G6 then E7 then silence.
    ivs = '{G6, G6, G6, E7, E7, E7, E7};
    run_model();
    check("pin_g6e7_count", exp_q.size(), 2);
    check("pin_g6_dur", exp_q[0].dur, 960);
    check("pin_e7_id", exp_q[1].id, 2);
    check("pin_e7_dur", exp_q[1].dur, 760);
    drive_ivs();
    silence();
    drain("g6e7_drain");

    // Window boundary: G7+TOL accepted, G7+TOL+1 rejected.
    ivs = '{G7 + TOL, G7 + TOL + 1};
    run_model();
    check("pin_bound_dur", exp_q[0].dur, 165);
    check("pin_bound_bad", exp_bad, 1);
    edge_after(200);
    edge_after(G7 + TOL);
    check("bound_tone_on", int'(tone_on), 1);
    edge_after(G7 + TOL + 1);
    check("bound_tone_off", int'(tone_on), 0);
    silence();
    drain("bound_drain");
    check("bound_bad_count", bad_seen, exp_bad);

    // Isolated edge then silence.
    edge_after(200);
    silence();
    check("iso_tone_on", int'(tone_on), 0);
    check("iso_bad_count", bad_seen, exp_bad);
    check("iso_no_vld", int'(note_vld), 0);

    // Consumer stalled across two complete notes.
    note_rdy = 1'b0;
    ivs = '{G6, G6, G6, C7, C7, C7};
    drive_ivs();
    silence();
    check("stall_vld", int'(note_vld), 1);
    check("stall_head_id", int'(note_id), 0);
    check("stall_head_dur", int'(note_dur), 960);
    push_ev(0, 960);
`ifdef PIEZO_RX_FIFO_EN
    push_ev(1, 720);
    check("stall_ovf", int'(ovf), 0);
`else
    check("stall_ovf", int'(ovf), 1);
`endif
    note_rdy = 1'b1;
    drain("stall_drain");
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    cyc();
    check("ovf_cleared", int'(ovf), 0);

    // Reset in the middle of a G6 note.
    edge_after(200);
    repeat (3) edge_after(G6);
    check("mid_g6_tone_on", int'(tone_on), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tone_on", int'(tone_on), 0);
    check("arst_note_vld", int'(note_vld), 0);
    check("arst_note_dur", int'(note_dur), 0);
    check("arst_ovf", int'(ovf), 0);
    repeat (3) cyc();
    rst_n = 1'b1;
    silence();
    check("arst_no_event", int'(note_vld), 0);

    // Randomised bursts with a randomly stalling consumer.
    rand_rdy = 1;
    for (int b = 0; b < 20; b++) begin
      int n, k, r, p;
      ivs.delete();
      n = $urandom_range(2, 9);
      k = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        if (r < 2) begin
          case ($urandom_range(0, 2))
            0: p = 170 + $urandom_range(0, 10);
            1: p = 205 + $urandom_range(0, 20);
            default: p = 260 + $urandom_range(0, 40);
          endcase
        end else begin
          if (r < 5) k = $urandom_range(0, 3);
          p = per_of(k) - TOL + $urandom_range(0, 2 * TOL);
        end
        ivs.push_back(p);
      end
      run_model();
      drive_ivs();
      silence();
    end
    rand_rdy = 0;
    note_rdy = 1'b1;
    drain("rand_drain");
    check("rand_bad_count", bad_seen, exp_bad);
    check("rand_ovf", int'(ovf), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
